// File: rtl/traj_recorder.sv
// Step-tuple recorder: FIFO-buffers simulator steps, accumulates a saturating discounted return.
// Optional per-action step histogram enabled by defining TRAJ_STATS_EN.
module traj_recorder #(
    parameter int DEPTH = 16,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             max_steps,
    input  logic [15:0]             discount,
    input  logic                    step_valid,
    input  logic [1:0]              action,
    input  logic                    observation,
    input  logic                    cur_state,
    input  logic [31:0]             reward,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [51:0]             rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [15:0]             drop_cnt,
    output logic signed [ACC_W-1:0] ret,
    output logic [63:0]             act_hist
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = 52;
    localparam logic signed [ACC_W-1:0] RET_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RET_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           mem_q [DEPTH];
    logic [AW:0]             wr_ptr_q, rd_ptr_q;
    logic [15:0]             step_cnt_q, disc_pow_q, drop_cnt_q;
    logic signed [ACC_W-1:0] ret_q, ret_d;
    logic                    done_q, done_d, overflow_q;

    logic                    empty, full, pop, step_run, wr_en, drop, hit;
    logic [15:0]             cnt_inc, disc_d;
    logic [31:0]             disc_prod;
    logic signed [48:0]      prod;
    logic signed [32:0]      term;
    logic signed [ACC_W:0]   sum;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = !empty && rd_ready;
    // start has priority over a coincident step: the restart wins and the step is not recorded
    assign step_run = step_valid && (state_q == S_RUN) && !start;
    assign wr_en    = step_run && (!full || pop);
    assign drop     = step_run && full && !pop;
    assign cnt_inc  = step_cnt_q + 16'd1;
    assign hit      = (max_steps != 16'd0) && (cnt_inc == max_steps);

    assign prod      = $signed(reward) * $signed({1'b0, disc_pow_q});
    assign term      = prod[48:16];
    assign sum       = {ret_q[ACC_W-1], ret_q} + {{(ACC_W-32){term[32]}}, term};
    assign disc_prod = disc_pow_q * discount;
    assign disc_d    = disc_prod[31:16];

    always_comb begin
        ret_d = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            ret_d = sum[ACC_W] ? RET_MIN : RET_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        if (start) begin
            state_d = S_RUN;
            done_d  = 1'b0;
        end else if (step_run && hit) begin
            state_d = S_DONE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {step_cnt_q, action, observation, cur_state, reward};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            step_cnt_q <= '0;
            disc_pow_q <= 16'hFFFF;
            drop_cnt_q <= '0;
            ret_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (start) begin
                step_cnt_q <= '0;
                disc_pow_q <= 16'hFFFF;
                drop_cnt_q <= '0;
                ret_q      <= '0;
                overflow_q <= 1'b0;
            end else if (step_run) begin
                step_cnt_q <= cnt_inc;
                disc_pow_q <= disc_d;
                ret_q      <= ret_d;
                if (drop) begin
                    overflow_q <= 1'b1;
                    if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

`ifdef TRAJ_STATS_EN
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hist
            logic [15:0] hist_q;
            always_ff @(posedge clk) begin
                if (rst || start) begin
                    hist_q <= '0;
                end else if (step_run && action == gi[1:0] && hist_q != 16'hFFFF) begin
                    hist_q <= hist_q + 16'd1;
                end
            end
            assign act_hist[16*gi +: 16] = hist_q;
        end
    endgenerate
`else
    assign act_hist = '0;
`endif

    assign rd_valid = !empty;
    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign ret      = ret_q;
endmodule

// File: tb/tb_traj_recorder.sv
// Directed bench for traj_recorder: scoreboard queue of expected FIFO entries plus a return model.
module tb_traj_recorder;
    localparam int DEPTH = 16;
    localparam int ACC_W = 40;
    localparam longint RMAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint RMIN = -(longint'(1) <<< (ACC_W-1));

    logic clk, rst, start, step_valid, observation, cur_state, rd_valid, rd_ready;
    logic busy, done, overflow;
    logic [15:0] max_steps, discount, drop_cnt;
    logic [1:0]  action;
    logic [31:0] reward;
    logic [51:0] rd_data;
    logic signed [ACC_W-1:0] ret;
    logic [63:0] act_hist;

    traj_recorder #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .max_steps(max_steps), .discount(discount),
        .step_valid(step_valid), .action(action), .observation(observation),
        .cur_state(cur_state), .reward(reward), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .busy(busy), .done(done), .overflow(overflow),
        .drop_cnt(drop_cnt), .ret(ret), .act_hist(act_hist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [51:0] sb [$];

    bit          m_run;
    logic [15:0] m_cnt, m_max, m_disc, m_df, m_drop;
    longint      m_ret;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-12s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] ms, input logic [15:0] df);
        max_steps = ms;
        discount  = df;
        start     = 1'b1;
        tick();
        start  = 1'b0;
        m_run  = 1'b1;
        m_cnt  = '0;
        m_max  = ms;
        m_df   = df;
        m_disc = 16'hFFFF;
        m_ret  = 0;
        m_drop = '0;
    endtask

    task automatic do_step(input logic [1:0] a, input logic o, input logic s,
                           input logic [31:0] r, input bit do_pop);
        logic [51:0] ent;
        longint      t;
        logic [31:0] dp;
        if (do_pop && sb.size() > 0) begin
            chk("pop_valid", 64'(rd_valid), 64'd1);
            chk("pop_data", 64'(rd_data), 64'(sb.pop_front()));
            rd_ready = 1'b1;
        end
        action = a; observation = o; cur_state = s; reward = r;
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        rd_ready   = 1'b0;
        if (m_run) begin
            ent = {m_cnt, a, o, s, r};
            if (sb.size() < DEPTH) sb.push_back(ent);
            else if (m_drop != 16'hFFFF) m_drop++;
            t = (longint'($signed(r)) * longint'({48'd0, m_disc})) >>> 16;
            m_ret = m_ret + t;
            if (m_ret > RMAX) m_ret = RMAX;
            if (m_ret < RMIN) m_ret = RMIN;
            dp = m_disc * m_df;
            m_disc = dp[31:16];
            m_cnt++;
            if (m_max != 0 && m_cnt == m_max) m_run = 1'b0;
        end
        $display("step a=%0d r=%h ret=%h drop=%0d", a, r, ret, drop_cnt);
    endtask

    task automatic drain_one();
        chk("rd_valid", 64'(rd_valid), 64'd1);
        chk("rd_data", 64'(rd_data), 64'(sb.pop_front()));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic drain_all();
        while (sb.size() > 0) drain_one();
        chk("rd_empty", 64'(rd_valid), 64'd0);
    endtask

    logic [63:0]             hist_exp;
    logic signed [ACC_W-1:0] prev_ret;

    initial begin
        rst = 1'b1; start = 1'b0; step_valid = 1'b0; rd_ready = 1'b0;
        max_steps = '0; discount = '0; action = '0; observation = 1'b0;
        cur_state = 1'b0; reward = '0; m_run = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdvalid", 64'(rd_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ret", 64'(ret), 64'd0);
        chk("rst_hist", act_hist, 64'd0);

        // step_valid in IDLE is ignored
        do_step(2'd1, 1'b1, 1'b0, 32'h0001_0000, 1'b0);
        chk("idle_rdvalid", 64'(rd_valid), 64'd0);

        // three-step episode with halving discount
        do_start(16'd3, 16'h8000);
        chk("run_busy", 64'(busy), 64'd1);
        do_step(2'd0, 1'b0, 1'b1, 32'h0001_0000, 1'b0);
        do_step(2'd1, 1'b1, 1'b0, 32'h0001_0000, 1'b0);
        do_step(2'd2, 1'b1, 1'b1, 32'h0001_0000, 1'b0);
        chk("ep_ret", 64'(ret), 64'h1BFFD);
        chk("ep_ret_model", 64'(ret), 64'(m_ret));
        chk("ep_done", 64'(done), 64'd1);
        chk("ep_busy", 64'(busy), 64'd0);
        do_step(2'd3, 1'b0, 1'b0, 32'h0001_0000, 1'b0);
        chk("post_ret", 64'(ret), 64'h1BFFD);
        chk("post_drop", 64'(drop_cnt), 64'd0);
        drain_all();

        // overflow: 20 steps into 16 entries
        do_start(16'd0, 16'h8000);
        for (int i = 0; i < 20; i++) do_step(2'(i), 1'(i), 1'(i >> 1), 32'(i * 1000 - 7000), 1'b0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drop", 64'(drop_cnt), 64'd4);
        chk("ovf_ret", 64'(ret), 64'(m_ret));
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_idx", 64'(rd_data[51:36]), 64'(i));
            drain_one();
        end
        chk("ovf_empty", 64'(rd_valid), 64'd0);

        // full FIFO with simultaneous write and read: no drop
        do_start(16'd0, 16'hC000);
        for (int i = 0; i < DEPTH; i++) do_step(2'(3 - (i % 4)), 1'b0, 1'b1, 32'hFFFF_0000 + 32'(i), 1'b0);
        chk("full_drop0", 64'(drop_cnt), 64'd0);
        do_step(2'd2, 1'b1, 1'b1, 32'h0000_1234, 1'b1);
        chk("wr_rd_ovf", 64'(overflow), 64'd0);
        chk("wr_rd_drop", 64'(drop_cnt), 64'd0);
        do_step(2'd1, 1'b0, 1'b0, 32'h0000_5678, 1'b0);
        chk("still_full", 64'(drop_cnt), 64'(m_drop));
        chk("head_idx", 64'(rd_data[51:36]), 64'd1);
        drain_all();

        // positive saturation of the accumulator
        do_start(16'd0, 16'hFFFF);
        prev_ret = '0;
        for (int i = 0; i < 600; i++) begin
            do_step(2'd0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0);
            chk("sat_mono", 64'(ret >= prev_ret), 64'd1);
            prev_ret = ret;
        end
        chk("sat_max", 64'(ret), 64'(RMAX));
        chk("sat_model", 64'(ret), 64'(m_ret));
        drain_all();

        // reset mid-episode
        do_start(16'd0, 16'h8000);
        for (int i = 0; i < 5; i++) do_step(2'd1, 1'b1, 1'b1, 32'h0002_0000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        m_run = 1'b0;
        chk("mid_rdvalid", 64'(rd_valid), 64'd0);
        chk("mid_ret", 64'(ret), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        do_start(16'd2, 16'h8000);
        do_step(2'd0, 1'b1, 1'b0, 32'h0001_0000, 1'b0);
        do_step(2'd3, 1'b0, 1'b1, 32'h0001_0000, 1'b0);
        chk("fresh_ret", 64'(ret), 64'h17FFE);
        chk("fresh_done", 64'(done), 64'd1);
        drain_all();

        // per-action histogram
        do_start(16'd0, 16'h8000);
        do_step(2'd0, 1'b0, 1'b0, 32'd5, 1'b0);
        do_step(2'd1, 1'b0, 1'b0, 32'd5, 1'b0);
        do_step(2'd1, 1'b0, 1'b0, 32'd5, 1'b0);
        do_step(2'd3, 1'b0, 1'b0, 32'd5, 1'b0);
        do_step(2'd3, 1'b0, 1'b0, 32'd5, 1'b0);
        do_step(2'd3, 1'b0, 1'b0, 32'd5, 1'b0);
`ifdef TRAJ_STATS_EN
        hist_exp = {16'd3, 16'd0, 16'd2, 16'd1};
`else
        hist_exp = 64'd0;
`endif
        chk("act_hist", act_hist, hist_exp);
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/traj_recorder.md
Name: traj_recorder

Overview:
- Consumer end of the simulator step stream: captures each (action, observation, cur_state, reward) step tuple emitted by the POMDP simulator, once per step_valid pulse.
- Buffers the tuples in a FIFO and drains them over a valid/ready read port to a host/debug reader.
- Accumulates the episode's discounted return in fixed point, and signals episode completion after max_steps steps.

Parameters:
- DEPTH, 16: FIFO entries; power of two, >=2.
- ACC_W, 40: discounted-return accumulator width (signed).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse; begins a new episode
- max_steps  in  16  steps per episode; 0 = unbounded
- discount  in  16  unsigned Q0.16 discount factor
- step_valid  in  1  one-cycle strobe; step tuple is valid
- action  in  2  step action
- observation  in  1  step observation
- cur_state  in  1  step state
- reward  in  32  signed step reward
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  reader accepts the head entry
- rd_data  out  52  {step_idx[15:0], action[1:0], observation, cur_state, reward[31:0]}, MSB first
- busy  out  1  FSM in RUN
- done  out  1  episode complete, sticky until next start
- overflow  out  1  sticky; at least one step dropped
- drop_cnt  out  16  dropped steps, saturating at 0xFFFF
- ret  out  ACC_W  signed discounted return
- act_hist  out  64  four 16-bit per-action counters (feature-dependent)

Behaviour:
- Reset: FSM=IDLE; FIFO empty. All of the following clear to 0: rd_valid, busy, done, overflow, drop_cnt, ret, act_hist, step counter. disc_pow = 0xFFFF.
- FSM IDLE:
  - start -> RUN. Same edge: clear ret, step counter, drop_cnt, overflow, done and act_hist; load disc_pow = 0xFFFF.
  - FIFO contents are not flushed on start; they remain readable.
- FSM RUN:
  - On each step_valid, increment the step counter (16-bit) and update the return:
    - ret += sat((reward * disc_pow) >>> 16), signed 48-bit product arithmetic-shifted right 16.
    - The accumulator saturates at ACC_W signed min/max and never wraps.
    - disc_pow <= (disc_pow * discount) >> 16, truncating.
  - When max_steps != 0 and the post-increment count == max_steps: go to DONE and set done.
  - start while in RUN restarts the episode, with the same effects as the IDLE start.
- FSM DONE:
  - step_valid is ignored entirely: no write, no drop count.
  - start -> RUN.
- step_valid in IDLE is ignored.
- FIFO write, on step_valid in RUN:
  - Entry = current step index (pre-increment, 0-based) plus the tuple.
  - When full and no read handshake in the same cycle: entry is dropped, overflow is set, drop_cnt increments. The return and step counter still update.
  - When full and rd_valid&&rd_ready in the same cycle: the write is accepted with no drop.
- FIFO read:
  - rd_valid = !empty. rd_data = head entry, combinational from the register array.
  - Pop on rd_valid&&rd_ready.
  - A write into an empty FIFO gives rd_valid=1 on the next cycle; there is no same-cycle fall-through.
- Pointers: log2(DEPTH)-bit with wrap, plus an extra bit for full/empty.
- rst mid-episode: all state returns to reset values on the next edge; FIFO contents are lost.

Optional Feature:
- Macro TRAJ_STATS_EN.
- Defined: act_hist[16*a+:16] increments on each accepted-or-dropped RUN step with action==a, saturating at 0xFFFF, and clears on start.
- Undefined: act_hist is tied to 0 and no counters are synthesised.

Test Plan:
- Reset, then start with max_steps=3, discount=0x8000, and 3 steps of reward 0x00010000 -> FIFO holds step_idx 0,1,2.
  - ret = 0xFFFF + 0x7FFF + 0x3FFF (truncated products), i.e. 0x1BFFD.
  - done=1, busy=0.
  - A 4th step_valid has no effect.
- DEPTH=16, rd_ready=0, max_steps=0, 20 steps -> 16 entries stored, overflow=1, drop_cnt=4.
  - Then hold rd_ready=1 -> entries drain with step_idx 0..15, then rd_valid=0.
- FIFO full, step_valid and rd_ready in the same cycle -> no drop; occupancy stays 16; head advances by one.
- Reward 0x7FFFFFFF with discount=0xFFFF for 600 steps, ACC_W=40 -> ret never wraps and holds the positive maximum once reached.
- Assert rst during RUN after 5 steps -> next cycle: rd_valid=0, ret=0, busy=0; a subsequent start behaves as fresh.
- With TRAJ_STATS_EN: actions 0,1,1,3,3,3 -> act_hist = {3,0,2,1} (a3..a0). Without the macro -> act_hist=0.
